// File: rtl/debugger_pkg.sv
// Shared character codes, status encoding and state types for the debugger line editor.
package debugger_pkg;

    localparam logic [7:0] CHAR_CR  = 8'h0D;
    localparam logic [7:0] CHAR_LF  = 8'h0A;
    localparam logic [7:0] CHAR_BS  = 8'h08;
    localparam logic [7:0] CHAR_DEL = 8'h7F;
    localparam logic [7:0] CHAR_ESC = 8'h1B;
    localparam logic [7:0] CHAR_NAK = 8'h15;
    localparam logic [7:0] CHAR_BEL = 8'h07;
    localparam logic [7:0] CHAR_SP  = 8'h20;

    typedef enum logic [1:0] {
        LS_OK     = 2'd0,
        LS_CANCEL = 2'd1,
        LS_ABORT  = 2'd2
    } line_status_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_ECHO,
        ST_KILL,
        ST_DONE
    } editor_state_t;

    typedef enum logic {
        TX_WAIT,
        TX_HOLD
    } tx_phase_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    function automatic logic [7:0] fold_upper(input logic [7:0] c);
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            return c - 8'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/debugger_echo_seq.sv
// Echo byte queue (up to 3 bytes) that paces TX_START pulses against the UART busy flag.
module debugger_echo_seq
    import debugger_pkg::*;
#(
    parameter bit ENABLE = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        LOAD_i,
    input  logic [1:0]  LOAD_CNT_i,
    input  logic [23:0] LOAD_BYTES_i,
    input  logic        FLUSH_i,
    input  logic        TX_BUSY_i,
    output logic        TX_START_o,
    output logic [7:0]  TX_DATA_o,
    output logic        EMPTY_o
);

    tx_phase_t   ph_q, ph_d;
    logic [23:0] bytes_q, bytes_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            ph_q       <= TX_WAIT;
            bytes_q    <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            ph_q       <= ph_d;
            bytes_q    <= bytes_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // TX_DATA is left untouched on flush so an in-flight byte stays stable.
    always_comb begin
        ph_d       = ph_q;
        bytes_d    = bytes_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        if (FLUSH_i) begin
            cnt_d = '0;
            ph_d  = TX_WAIT;
        end else if (LOAD_i && ENABLE) begin
            bytes_d = LOAD_BYTES_i;
            cnt_d   = LOAD_CNT_i;
        end else begin
            unique case (ph_q)
                TX_WAIT: begin
                    if ((cnt_q != 2'd0) && !TX_BUSY_i) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = bytes_q[7:0];
                        bytes_d    = bytes_q >> 8;
                        cnt_d      = cnt_q - 2'd1;
                        ph_d       = TX_HOLD;
                    end
                end
                TX_HOLD: ph_d = TX_WAIT;
                default: ph_d = TX_WAIT;
            endcase
        end
    end

    assign TX_START_o = tx_start_q;
    assign TX_DATA_o  = tx_data_q;
    // Empty only once the last byte has actually left the transmitter.
    assign EMPTY_o    = !ENABLE || ((cnt_q == 2'd0) && (ph_q == TX_WAIT) && !TX_BUSY_i);

endmodule

// File: rtl/debugger_line_editor.sv
// Console line editor: collects one command line from UART RX with echo and simple editing.
module debugger_line_editor
    import debugger_pkg::*;
#(
    parameter int unsigned COUNT     = 64,
    parameter bit          ECHO      = 1'b1,
    parameter bit          CASE_FOLD = 1'b0
) (
    input  logic                         CLK,
    input  logic                         RESET_n,
    input  logic [7:0]                   RX_DATA,
    input  logic                         RX_READY,
    output logic                         RX_READ,
    output logic [7:0]                   TX_DATA,
    output logic                         TX_START,
    input  logic                         TX_BUSY,
    input  logic                         REQ_n,
    output logic [8*COUNT-1:0]           DATA,
    output logic [$clog2(COUNT+1)-1:0]   LENGTH,
    output logic [1:0]                   STATUS,
    output logic                         ACK_n
);

    localparam int unsigned LW = $clog2(COUNT + 1);
    localparam int unsigned AW = $clog2(COUNT);
    localparam logic [LW-1:0] LEN_MAX = LW'(COUNT);

    editor_state_t state_q, state_d;
    editor_state_t ret_q, ret_d;
    logic [LW-1:0] len_q, len_d;
    line_status_t  status_q, status_d;
    logic          ack_n_q, ack_n_d;
    logic          rx_read_q, rx_read_d;

    logic [7:0]    line_q [COUNT];
    logic          buf_we;
    logic [7:0]    rx_char;

    logic          q_load, q_flush, echo_empty;
    logic [1:0]    q_cnt;
    logic [23:0]   q_bytes;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_RUN;
            len_q     <= '0;
            status_q  <= LS_OK;
            ack_n_q   <= 1'b1;
            rx_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            len_q     <= len_d;
            status_q  <= status_d;
            ack_n_q   <= ack_n_d;
            rx_read_q <= rx_read_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (buf_we) begin
            line_q[len_q[AW-1:0]] <= rx_char;
        end
    end

    always_comb begin
        rx_char = CASE_FOLD ? fold_upper(RX_DATA) : RX_DATA;
    end

    // ret_q holds where to go once the echo queue drains (RUN, KILL or DONE).
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        len_d     = len_q;
        status_d  = status_q;
        rx_read_d = 1'b0;
        buf_we    = 1'b0;
        q_load    = 1'b0;
        q_cnt     = '0;
        q_bytes   = '0;
        q_flush   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!REQ_n) begin
                    len_d    = '0;
                    status_d = LS_OK;
                    state_d  = ST_RUN;
                end
            end
            ST_DONE: begin
                if (REQ_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (REQ_n) begin
                    status_d = LS_ABORT;
                    q_flush  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    unique case (state_q)
                        ST_RUN: begin
                            if (RX_READY) begin
                                rx_read_d = 1'b1;
                                ret_d     = ST_RUN;
                                state_d   = ST_GAP;
                                if (is_printable(RX_DATA)) begin
                                    q_load = 1'b1;
                                    q_cnt  = 2'd1;
                                    if (len_q < LEN_MAX) begin
                                        buf_we  = 1'b1;
                                        len_d   = len_q + LW'(1);
                                        q_bytes = {16'h0000, rx_char};
                                    end else begin
                                        q_bytes = {16'h0000, CHAR_BEL};
                                    end
                                end else if ((RX_DATA == CHAR_BS) || (RX_DATA == CHAR_DEL)) begin
                                    q_load = 1'b1;
                                    if (len_q != '0) begin
                                        len_d   = len_q - LW'(1);
                                        q_cnt   = 2'd3;
                                        q_bytes = {CHAR_BS, CHAR_SP, CHAR_BS};
                                    end else begin
                                        q_cnt   = 2'd1;
                                        q_bytes = {16'h0000, CHAR_BEL};
                                    end
                                end else if (RX_DATA == CHAR_NAK) begin
                                    ret_d = ST_KILL;
                                end else if ((RX_DATA == CHAR_CR) || (RX_DATA == CHAR_ESC)) begin
                                    q_load  = 1'b1;
                                    q_cnt   = 2'd2;
                                    q_bytes = {8'h00, CHAR_LF, CHAR_CR};
                                    ret_d   = ST_DONE;
                                    if (RX_DATA == CHAR_ESC) begin
                                        len_d    = '0;
                                        status_d = LS_CANCEL;
                                    end
                                end
                            end
                        end
                        ST_GAP: begin
                            state_d = echo_empty ? ret_q : ST_ECHO;
                        end
                        ST_ECHO: begin
                            if (echo_empty) begin
                                state_d = ret_q;
                            end
                        end
                        ST_KILL: begin
                            if (len_q == '0) begin
                                state_d = ST_RUN;
                            end else begin
                                len_d   = len_q - LW'(1);
                                q_load  = 1'b1;
                                q_cnt   = 2'd3;
                                q_bytes = {CHAR_BS, CHAR_SP, CHAR_BS};
                                ret_d   = ST_KILL;
                                state_d = ST_ECHO;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase

        ack_n_d = (state_d != ST_DONE);
    end

    always_comb begin
        for (int unsigned i = 0; i < COUNT; i++) begin
            DATA[8*i +: 8] = line_q[i];
        end
    end

    debugger_echo_seq #(
        .ENABLE(ECHO)
    ) u_echo (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .LOAD_i       (q_load),
        .LOAD_CNT_i   (q_cnt),
        .LOAD_BYTES_i (q_bytes),
        .FLUSH_i      (q_flush),
        .TX_BUSY_i    (TX_BUSY),
        .TX_START_o   (TX_START),
        .TX_DATA_o    (TX_DATA),
        .EMPTY_o      (echo_empty)
    );

    assign RX_READ = rx_read_q;
    assign LENGTH  = len_q;
    assign STATUS  = status_q;
    assign ACK_n   = ack_n_q;

endmodule
